// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares the 8x16 register file between execute-stage operand reads and writeback-stage result writes.
// Latency: read grant to rd_valid 3 cycles, write grant to wr_done 2 cycles; one register-file operation in flight at a time.
// Backpressure: requesters hold req until their grant pulse; grants are only decoded in IDLE, so a busy arbiter simply stalls them.
// Optional feature: define REGARB_FWD_EN to let a read bypass a pending write to the same register (operand forwarded from wr_data).
module reg_file_arbiter #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 3,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // execute-stage read port
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  // writeback-stage write port
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic              wr_done,
  // register file side
  output logic              Reg_load,
  output logic [ADDR_W-1:0] Reg_addr_op1,
  output logic [ADDR_W-1:0] Reg_addr_op2,
  output logic [DATA_W-1:0] Reg_data_op1,
  output logic [DATA_W-1:0] Reg_data_op2,
  input  logic [DATA_W-1:0] Reg_Out_op1,
  input  logic [DATA_W-1:0] Reg_Out_op2
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    WR_ISSUE   = 2'd3
  } state_t;

  localparam int                  STREAK_W   = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  state_t              state;
  logic [STREAK_W-1:0] streak;       // consecutive write grants while a read waited
  logic                streak_full;
  logic                pick_wr;
  logic                pick_rd;

`ifdef REGARB_FWD_EN
  // Operand bypass state captured when a read overtakes a pending write.
  logic                fwd1;
  logic                fwd2;
  logic [DATA_W-1:0]   fwd_data;
`else
  logic                hazard;
`endif

  // Arbitration decision from the live request lines; only acted on in IDLE.
  always_comb begin
    streak_full = (streak == STREAK_MAX);
`ifdef REGARB_FWD_EN
    // Forwarding makes read-after-write ordering safe, so only the streak limit matters.
    pick_wr = wr_req && (!rd_req || !streak_full);
`else
    // Without forwarding a read touching the pending destination must wait for the write.
    hazard  = rd_req && wr_req && ((wr_addr == rd_addr1) || (wr_addr == rd_addr2));
    pick_wr = wr_req && (!rd_req || !streak_full || hazard);
`endif
    pick_rd = rd_req && !pick_wr;
  end

  // Grants are decoded straight from IDLE so a requester sees acceptance in the cycle its request is sampled.
  assign rd_grant = (state == IDLE) && pick_rd;
  assign wr_grant = (state == IDLE) && pick_wr;

  // Main sequencer: arbitration, register-file drive, operand capture and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      streak       <= '0;
      rd_valid     <= 1'b0;
      wr_done      <= 1'b0;
      rd_data1     <= '0;
      rd_data2     <= '0;
      Reg_load     <= 1'b0;
      Reg_addr_op1 <= '0;
      Reg_addr_op2 <= '0;
      Reg_data_op1 <= '0;
      Reg_data_op2 <= '0;
`ifdef REGARB_FWD_EN
      fwd1         <= 1'b0;
      fwd2         <= 1'b0;
      fwd_data     <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      Reg_load <= 1'b0;
      case (state)
        IDLE: begin
          // A read that is not waiting cannot be starved, so the streak restarts.
          if (!rd_req) begin
            streak <= '0;
          end
          if (pick_wr) begin
            // Address/data registers double as the latched request; they hold after the op.
            state        <= WR_ISSUE;
            Reg_load     <= 1'b1;
            Reg_addr_op1 <= wr_addr;
            Reg_addr_op2 <= wr_addr;
            Reg_data_op1 <= wr_data;
            Reg_data_op2 <= wr_data;
            if (rd_req && !streak_full) begin
              streak <= streak + 1'b1;
            end
          end else if (pick_rd) begin
            state        <= RD_ISSUE;
            Reg_addr_op1 <= rd_addr1;
            Reg_addr_op2 <= rd_addr2;
            streak       <= '0;
`ifdef REGARB_FWD_EN
            fwd1     <= wr_req && (wr_addr == rd_addr1);
            fwd2     <= wr_req && (wr_addr == rd_addr2);
            fwd_data <= wr_data;
`endif
          end
        end
        RD_ISSUE: begin
          // Register file samples the addresses at the end of this cycle.
          state <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          state    <= IDLE;
          rd_valid <= 1'b1;
`ifdef REGARB_FWD_EN
          rd_data1 <= fwd1 ? fwd_data : Reg_Out_op1;
          rd_data2 <= fwd2 ? fwd_data : Reg_Out_op2;
`else
          rd_data1 <= Reg_Out_op1;
          rd_data2 <= Reg_Out_op2;
`endif
        end
        WR_ISSUE: begin
          // Register file commits at the end of this cycle; Reg_load falls by default.
          state   <= IDLE;
          wr_done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: randomized scoreboard bench for reg_file_arbiter with a behavioural register file.
// Expected read operands and write commits are queued at grant time and popped by a separate monitor.
// Arbitration winners are predicted from the request lines and a simple write-run count.
`timescale 1ns/1ps
module tb_reg_file_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic          rd_grant, rd_valid;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_grant, wr_done;
  logic          Reg_load;
  logic [AW-1:0] Reg_addr_op1, Reg_addr_op2;
  logic [DW-1:0] Reg_data_op1, Reg_data_op2;
  logic [DW-1:0] Reg_Out_op1, Reg_Out_op2;

  always #5 clk = ~clk;

  reg_file_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WR_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_done(wr_done),
    .Reg_load(Reg_load), .Reg_addr_op1(Reg_addr_op1), .Reg_addr_op2(Reg_addr_op2),
    .Reg_data_op1(Reg_data_op1), .Reg_data_op2(Reg_data_op2),
    .Reg_Out_op1(Reg_Out_op1), .Reg_Out_op2(Reg_Out_op2)
  );

  // Register file: write on Reg_load, registered read of both ports.
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (Reg_load) mem[Reg_addr_op1] <= Reg_data_op1;
    Reg_Out_op1 <= mem[Reg_addr_op1];
    Reg_Out_op2 <= mem[Reg_addr_op2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { int g; logic [DW-1:0] d1; logic [DW-1:0] d2; } rd_exp_t;
  typedef struct { int g; logic [AW-1:0] a; logic [DW-1:0] d; } wr_exp_t;
  rd_exp_t rq[$];
  wr_exp_t wq[$];

  logic [DW-1:0] ref_mem [8];   // architectural register contents as seen by grant order
  int run = 0;                  // write grants in a row while a read has been waiting

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: check who won, update the model, queue the expected outcome.
  task automatic observe();
    logic          hz;
    logic          exp_wr;
    logic [DW-1:0] d1, d2;
    check("single_grant", {31'd0, rd_grant & wr_grant}, 32'd0);
    if (!rd_req) run = 0;
    if (rd_req && wr_req && (rd_grant || wr_grant)) begin
      hz = (wr_addr == rd_addr1) || (wr_addr == rd_addr2);
`ifdef REGARB_FWD_EN
      exp_wr = (run < MAXS);
`else
      exp_wr = hz || (run < MAXS);
`endif
      check("arb_winner_is_write", {31'd0, wr_grant}, {31'd0, exp_wr});
    end
    if (wr_grant) begin
      check("wr_grant_has_req", {31'd0, wr_req}, 32'd1);
      run = rd_req ? ((run < MAXS) ? run + 1 : MAXS) : 0;
      ref_mem[wr_addr] = wr_data;
      wq.push_back('{cyc, wr_addr, wr_data});
    end
    if (rd_grant) begin
      check("rd_grant_has_req", {31'd0, rd_req}, 32'd1);
      d1 = ref_mem[rd_addr1];
      d2 = ref_mem[rd_addr2];
`ifdef REGARB_FWD_EN
      if (wr_req && !wr_grant && wr_addr == rd_addr1) d1 = wr_data;
      if (wr_req && !wr_grant && wr_addr == rd_addr2) d2 = wr_data;
`endif
      rq.push_back('{cyc, d1, d2});
      run = 0;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_valid) begin
          if (rq.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_valid_unexpected: got rd_valid=1 expected none (cycle %0d)", cyc);
          end else begin
            re = rq.pop_front();
            check("rd_latency", cyc - re.g, 32'd3);
            check("rd_data1", {16'd0, rd_data1}, {16'd0, re.d1});
            check("rd_data2", {16'd0, rd_data2}, {16'd0, re.d2});
          end
        end
        if (Reg_load) begin
          if (wq.size() == 0) begin
            tests++; fails++;
            $display("FAIL reg_load_unexpected: got Reg_load=1 expected 0 (cycle %0d)", cyc);
          end else begin
            we = wq[0];
            check("wr_issue_latency", cyc - we.g, 32'd1);
            check("wr_addr_op1", {29'd0, Reg_addr_op1}, {29'd0, we.a});
            check("wr_addr_op2", {29'd0, Reg_addr_op2}, {29'd0, we.a});
            check("wr_data_op1", {16'd0, Reg_data_op1}, {16'd0, we.d});
            check("wr_data_op2", {16'd0, Reg_data_op2}, {16'd0, we.d});
          end
        end
        if (wr_done) begin
          if (wq.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_done_unexpected: got wr_done=1 expected none (cycle %0d)", cyc);
          end else begin
            we = wq.pop_front();
            check("wr_done_latency", cyc - we.g, 32'd2);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = wr_grant;
      observe();
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL wr_grant_timeout: got no grant expected grant for r%0d", a);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bit got = 0;
    rd_addr1 = a1; rd_addr2 = a2; rd_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = rd_grant;
      observe();
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL rd_grant_timeout: got no grant expected grant for r%0d/r%0d", a1, a2);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      observe();
    end
    @(posedge clk); #1;
  endtask

  initial begin : stim
    bit rg, wg, rd_done_h, wr_done_h;
    int rd_gap, wr_gap, rd_wait, wr_wait;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_grant", {31'd0, rd_grant}, 32'd0);
    check("rst_wr_grant", {31'd0, wr_grant}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_wr_done", {31'd0, wr_done}, 32'd0);
    check("rst_reg_load", {31'd0, Reg_load}, 32'd0);
    check("rst_rd_data1", {16'd0, rd_data1}, 32'd0);
    check("rst_rd_data2", {16'd0, rd_data2}, 32'd0);
    check("rst_addr_op1", {29'd0, Reg_addr_op1}, 32'd0);
    check("rst_addr_op2", {29'd0, Reg_addr_op2}, 32'd0);
    check("rst_data_op1", {16'd0, Reg_data_op1}, 32'd0);
    check("rst_data_op2", {16'd0, Reg_data_op2}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Give every register a known value through the arbiter.
    for (int i = 0; i < 8; i++) do_write(AW'(i), 16'h0100 + 16'(i));

    // Operand read of r0/r1 holding 10/1000.
    do_write(3'd0, 16'd10);
    do_write(3'd1, 16'd1000);
    do_read(3'd0, 3'd1);
    idle_cycles(4);

    // Write r5 then read it back on both ports.
    do_write(3'd5, 16'h1234);
    do_read(3'd5, 3'd5);
    idle_cycles(4);

    // Concurrent hazard: write r2=77 with a read of r2/r3 pending at the same time.
    wr_addr = 3'd2; wr_data = 16'd77; wr_req = 1'b1;
    rd_addr1 = 3'd2; rd_addr2 = 3'd3; rd_req = 1'b1;
    rd_done_h = 0; wr_done_h = 0;
    for (int i = 0; i < 40 && !(rd_done_h && wr_done_h); i++) begin
      @(negedge clk);
      rg = rd_grant; wg = wr_grant;
      observe();
      @(posedge clk); #1;
      if (rg) begin rd_req = 1'b0; rd_done_h = 1; end
      if (wg) begin wr_req = 1'b0; wr_done_h = 1; end
    end
    check("hazard_both_served", {30'd0, rd_done_h, wr_done_h}, 32'd3);
    rd_req = 1'b0; wr_req = 1'b0;
    idle_cycles(5);

    // Reset while the write is on the register-file port.
    wr_addr = 3'd6; wr_data = 16'hBEEF; wr_req = 1'b1;
    wg = 0;
    for (int i = 0; i < 20 && !wg; i++) begin
      @(negedge clk);
      wg = wr_grant;
    end
    check("rst_mid_wr_grant", {31'd0, wg}, 32'd1);
    @(posedge clk); #1;
    wr_req = 1'b0;
    check("rst_mid_load_before", {31'd0, Reg_load}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_load_dropped", {31'd0, Reg_load}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_wr_done", {31'd0, wr_done}, 32'd0);
    end
    check("rst_mid_reg_unchanged", {16'd0, mem[6]}, {16'd0, ref_mem[6]});
    @(posedge clk); #1;
    run = 0;
    do_read(3'd6, 3'd6);
    idle_cycles(4);

    // Randomized traffic from both requesters, with occasional abandoned requests.
    rd_gap = 0; wr_gap = 0; rd_wait = 0; wr_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rg = rd_grant; wg = wr_grant;
      observe();
      @(posedge clk); #1;
      if (rg) begin
        rd_req = 1'b0; rd_gap = $urandom_range(5, 2);
      end else if (rd_req) begin
        rd_wait++;
        if (rd_wait > 80) begin
          tests++; fails++;
          $display("FAIL rd_starved: got %0d cycles waiting expected under 80", rd_wait);
          rd_req = 1'b0; rd_gap = 2;
        end else if ($urandom_range(24, 0) == 0) begin
          rd_req = 1'b0; rd_gap = $urandom_range(5, 2);
        end
      end else if (rd_gap > 0) begin
        rd_gap--;
      end else if ($urandom_range(3, 0) != 0) begin
        rd_req = 1'b1; rd_wait = 0;
        rd_addr1 = AW'($urandom_range(3, 0));
        rd_addr2 = AW'($urandom_range(7, 0));
      end
      if (wg) begin
        wr_req = 1'b0; wr_gap = $urandom_range(1, 0);
      end else if (wr_req) begin
        wr_wait++;
        if (wr_wait > 80) begin
          tests++; fails++;
          $display("FAIL wr_starved: got %0d cycles waiting expected under 80", wr_wait);
          wr_req = 1'b0; wr_gap = 1;
        end else if ($urandom_range(24, 0) == 0) begin
          wr_req = 1'b0; wr_gap = 1;
        end
      end else if (wr_gap > 0) begin
        wr_gap--;
      end else if ($urandom_range(7, 0) != 0) begin
        wr_req = 1'b1; wr_wait = 0;
        wr_addr = AW'($urandom_range(3, 0));
        wr_data = DW'($urandom);
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    idle_cycles(8);
    check("rd_queue_drained", rq.size(), 32'd0);
    check("wr_queue_drained", wq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
